// File: rtl/icb_ddr_seq_if.sv
// icb_ddr_seq_if: ICB command/response bus between the line sequencer and the DDR bridge registers
interface icb_ddr_seq_if;
  logic        m_icb_cmd_valid;
  logic        m_icb_cmd_ready;
  logic [31:0] m_icb_cmd_addr;
  logic        m_icb_cmd_read;
  logic [31:0] m_icb_cmd_wdata;
  logic [3:0]  m_icb_cmd_wmask;
  logic        m_icb_rsp_valid;
  logic        m_icb_rsp_ready;
  logic        m_icb_rsp_err;
  logic [31:0] m_icb_rsp_rdata;
  modport master (
    output m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_rsp_ready,
    input  m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, m_icb_rsp_rdata
  );
  modport slave (
    input  m_icb_cmd_valid, m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask, m_icb_rsp_ready,
    output m_icb_cmd_ready, m_icb_rsp_valid, m_icb_rsp_err, m_icb_rsp_rdata
  );
endinterface

// File: rtl/icb_ddr_seq.sv
// icb_ddr_seq: turns one 256-bit line request into the DDR bridge register sequence; DDR_SEQ_TIMEOUT_EN bounds STATE polling
module icb_ddr_seq #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter int          CTRL_GAP   = 16,
  parameter int          POLL_LIMIT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [27:0]   req_addr,
  input  logic [255:0]  req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [255:0]  rsp_rdata,
  output logic          rsp_err,
  output logic          busy,
  icb_ddr_seq_if.master icb
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RSP, GAP, POLL, RESP} state_t;
  localparam logic [3:0] LAST = 4'd13;
  localparam int GW = $clog2(CTRL_GAP + 1);
  state_t state, nxt;
  logic wr_q;
  logic [27:0] addr_q;
  logic [255:0] wdata_q;
  logic [3:0] step, step_nx, poll_step;
  logic [GW-1:0] gap_cnt;
  logic [2:0] wi, ri;
  logic [7:0] off;
  logic rd;
  logic [31:0] wd;
  logic issuing, take, is_poll, done, tmo, retry, gap_done, rd_line;
  assign poll_step = wr_q ? 4'd12 : 4'd4;
  assign wi = 3'(step - 4'd2);
  assign ri = 3'(step - 4'd5);
  assign issuing = state == ISSUE || state == POLL;
  assign take = icb.m_icb_rsp_valid && (state == WAIT_RSP || (issuing && icb.m_icb_cmd_ready));
  assign is_poll = step == poll_step;
  assign done = wr_q ? icb.m_icb_rsp_rdata[1] : icb.m_icb_rsp_rdata[0];
  assign retry = is_poll && !done && !tmo;
  assign step_nx = tmo ? LAST : retry ? step : step + 4'd1;
  assign gap_done = gap_cnt == GW'(CTRL_GAP - 1);
  assign rd_line = !wr_q && step >= 4'd5 && step <= 4'd12;
`ifdef DDR_SEQ_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt;
  assign tmo = is_poll && !done && poll_cnt == PW'(POLL_LIMIT - 1);
  // count STATE reads of the current request
  always_ff @(posedge clk)
    if (!rst_n || (req_valid && req_ready)) poll_cnt <= '0;
    else if (take && is_poll) poll_cnt <= poll_cnt + 1'b1;
`else
  assign tmo = 1'b0;
`endif
  // decode the current step into a register offset, direction and write data
  always_comb begin
    off = 8'h00;
    rd = 1'b0;
    wd = 32'h0;
    if (step == 4'd0) off = 8'h04;
    else if (step == 4'd1 || step == LAST) off = 8'h00;
    else if (is_poll) begin
      off = 8'h04;
      rd = 1'b1;
    end else if (wr_q) begin
      if (step <= 4'd9) begin
        off = 8'h08 + {3'b0, wi, 2'b00};
        wd = wdata_q[{wi, 5'b0} +: 32];
      end else if (step == 4'd10) begin
        off = 8'h28;
        wd = {4'b0, addr_q};
      end else wd = 32'd2;
    end else if (step == 4'd2) begin
      off = 8'h4C;
      wd = {4'b0, addr_q};
    end else if (step == 4'd3) wd = 32'd1;
    else begin
      off = 8'h2C + {3'b0, ri, 2'b00};
      rd = 1'b1;
    end
  end
  // state register
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : nxt;
  // next state and handshake outputs; a response in the handshake cycle skips WAIT_RSP
  always_comb begin
    nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    busy = state != IDLE;
    icb.m_icb_cmd_valid = 1'b0;
    icb.m_icb_cmd_addr = 32'h0;
    icb.m_icb_cmd_read = 1'b0;
    icb.m_icb_cmd_wdata = 32'h0;
    icb.m_icb_cmd_wmask = 4'hF;
    icb.m_icb_rsp_ready = 1'b1;
    if (state == IDLE) begin
      req_ready = 1'b1;
      if (req_valid) nxt = ISSUE;
    end
    if (issuing) begin
      icb.m_icb_cmd_valid = 1'b1;
      icb.m_icb_cmd_addr = BASE_ADDR + {24'h0, off};
      icb.m_icb_cmd_read = rd;
      icb.m_icb_cmd_wdata = wd;
      if (icb.m_icb_cmd_ready) nxt = WAIT_RSP;
    end
    if (take) nxt = step == 4'd1 ? GAP : step == LAST ? RESP : step_nx == poll_step ? POLL : ISSUE;
    if (state == GAP && gap_done) nxt = ISSUE;
    if (state == RESP) begin
      rsp_valid = 1'b1;
      if (rsp_ready) nxt = IDLE;
    end
  end
  // request latch, step sequencing, gap timer, sticky error and read line capture
  always_ff @(posedge clk)
    if (!rst_n) begin
      wr_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      step <= '0;
      gap_cnt <= '0;
      rsp_rdata <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (req_valid && req_ready) begin
        wr_q <= req_write;
        addr_q <= req_addr;
        wdata_q <= req_wdata;
        step <= '0;
        rsp_rdata <= '0;
        rsp_err <= 1'b0;
      end
      if (take) begin
        step <= step_nx;
        rsp_err <= rsp_err | icb.m_icb_rsp_err | tmo;
        if (rd_line) rsp_rdata[{ri, 5'b0} +: 32] <= icb.m_icb_rsp_rdata;
      end
      gap_cnt <= (state == GAP && !gap_done) ? gap_cnt + 1'b1 : '0;
    end
endmodule
